// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus send sequencer feeding the UART transmitter's edge-triggered
// tx_send/tx_ready handshake, with overflow reporting and a watchdog that
// abandons a byte if the transmitter never answers.
module uart_tx_fifo #(
    parameter int AW      = 4,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic          clock25,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    tx_byte,
    output logic          tx_send,
    input  logic          tx_ready,
    output logic          busy,
    output logic          timeout_err
);

    localparam int DEPTH = 2 ** AW;
    localparam int CW    = AW + 1;
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam int GAP_W = $clog2(GAP + 1);

    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    typedef enum logic [1:0] {
        ST_RECOVER,
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
    logic [7:0]       txByte_q, txByte_d;
    logic             txSend_q, txSend_d;
    logic             overflow_q, overflow_d;
    logic             timeoutErr_q, timeoutErr_d;
    logic [7:0]       mem_q [DEPTH];

    logic             wrAccept;
    logic             pop;

    // Status comes from the registered occupancy, so a write is judged
    // against the FIFO as it stood before this edge, even if a pop coincides.
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign wrAccept = wr_en && !full;
    assign pop      = (state_q == ST_IDLE) && !empty;

    assign count       = count_q;
    assign overflow    = overflow_q;
    assign tx_byte     = txByte_q;
    assign tx_send     = txSend_q;
    assign timeout_err = timeoutErr_q;
    assign busy        = !empty || (state_q != ST_IDLE);

    // Storage array; contents are don't-care after reset so it has no reset.
    always_ff @(posedge clock25) begin
        if (wrAccept) begin
            mem_q[wrPtr_q] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; a dropped write only raises overflow.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = wr_en && full;
        if (wrAccept) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        case ({wrAccept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Send sequencer: recover from a frame left in flight, pop, wait for the
    // transmitter (or give up), then hold tx_send low long enough for a new edge.
    always_comb begin
        state_d      = state_q;
        wd_d         = wd_q;
        gapCnt_d     = gapCnt_q;
        txByte_d     = txByte_q;
        txSend_d     = txSend_q;
        timeoutErr_d = 1'b0;
        case (state_q)
            ST_RECOVER: begin
                txSend_d = 1'b0;
                if (tx_ready || (wd_q == WD_MAX)) begin
                    state_d = ST_IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_IDLE: begin
                if (!empty) begin
                    txByte_d = mem_q[rdPtr_q];
                    txSend_d = 1'b1;
                    wd_d     = '0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    txSend_d = 1'b0;
                    gapCnt_d = '0;
                    state_d  = ST_GAP;
                end else if (wd_q == WD_MAX) begin
                    timeoutErr_d = 1'b1;
                    txSend_d     = 1'b0;
                    gapCnt_d     = '0;
                    state_d      = ST_GAP;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_GAP: begin
                txSend_d = 1'b0;
                if (gapCnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gapCnt_d = gapCnt_q + GAP_W'(1);
                end
            end
            default: begin
                txSend_d = 1'b0;
                state_d  = ST_RECOVER;
            end
        endcase
    end

    // State and control registers; reset lands in RECOVER with everything idle.
    always_ff @(posedge clock25 or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RECOVER;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            count_q      <= '0;
            wd_q         <= '0;
            gapCnt_q     <= '0;
            txByte_q     <= '0;
            txSend_q     <= 1'b0;
            overflow_q   <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            count_q      <= count_d;
            wd_q         <= wd_d;
            gapCnt_q     <= gapCnt_d;
            txByte_q     <= txByte_d;
            txSend_q     <= txSend_d;
            overflow_q   <= overflow_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios followed by random
// traffic, every cycle compared against a queue-based behavioural model.
module tb_uart_tx_fifo;

    localparam int AW      = 4;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 4096;
    localparam int DEPTH   = 16;

    logic        clock25 = 1'b0;
    logic        reset   = 1'b1;
    logic        wrEn    = 1'b0;
    logic [7:0]  wrData  = 8'h00;
    logic        txReady = 1'b0;
    logic        full;
    logic        empty;
    logic [AW:0] count;
    logic        overflow;
    logic [7:0]  txByte;
    logic        txSend;
    logic        busy;
    logic        timeoutErr;

    int checkCount = 0;
    int errorCount = 0;

    // Behavioural model: a byte queue plus a description of what the sender is doing.
    logic [7:0] modelQ[$];
    bit         mRecovering;
    int         mRecoverElapsed;
    bit         mSending;
    int         mSendElapsed;
    int         mGapLeft;
    bit         mTxSend;
    logic [7:0] mTxByte;
    bit         mOverflow;
    bit         mTimeout;

    uart_tx_fifo #(
        .AW(AW),
        .GAP(GAP),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock25(clock25),
        .reset(reset),
        .wr_en(wrEn),
        .wr_data(wrData),
        .full(full),
        .empty(empty),
        .count(count),
        .overflow(overflow),
        .tx_byte(txByte),
        .tx_send(txSend),
        .tx_ready(txReady),
        .busy(busy),
        .timeout_err(timeoutErr)
    );

    // 25 MHz system clock.
    always #20 clock25 = ~clock25;

    function automatic void modelReset();
        modelQ.delete();
        mRecovering     = 1'b1;
        mRecoverElapsed = 0;
        mSending        = 1'b0;
        mSendElapsed    = 0;
        mGapLeft        = 0;
        mTxSend         = 1'b0;
        mTxByte         = 8'h00;
        mOverflow       = 1'b0;
        mTimeout        = 1'b0;
    endfunction

    function automatic bit modelIdle();
        return !mRecovering && !mSending && (mGapLeft == 0);
    endfunction

    function automatic void modelStep(bit we, logic [7:0] d, bit rdy);
        bit wasFull;
        wasFull   = (modelQ.size() == DEPTH);
        mOverflow = we && wasFull;
        mTimeout  = 1'b0;
        if (mRecovering) begin
            if (rdy || (mRecoverElapsed == TIMEOUT - 1)) mRecovering = 1'b0;
            else mRecoverElapsed++;
        end else if (mSending) begin
            if (rdy) begin
                mSending = 1'b0;
                mTxSend  = 1'b0;
                mGapLeft = GAP;
            end else if (mSendElapsed == TIMEOUT - 1) begin
                mTimeout = 1'b1;
                mSending = 1'b0;
                mTxSend  = 1'b0;
                mGapLeft = GAP;
            end else begin
                mSendElapsed++;
            end
        end else if (mGapLeft > 0) begin
            mGapLeft--;
        end else if (modelQ.size() > 0) begin
            mTxByte      = modelQ.pop_front();
            mTxSend      = 1'b1;
            mSending     = 1'b1;
            mSendElapsed = 0;
        end
        if (we && !wasFull) modelQ.push_back(d);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic compareAll();
        checkOutput("count", 32'(count), 32'(modelQ.size()));
        checkOutput("full", 32'(full), 32'(modelQ.size() == DEPTH));
        checkOutput("empty", 32'(empty), 32'(modelQ.size() == 0));
        checkOutput("overflow", 32'(overflow), 32'(mOverflow));
        checkOutput("timeoutErr", 32'(timeoutErr), 32'(mTimeout));
        checkOutput("txSend", 32'(txSend), 32'(mTxSend));
        checkOutput("txByte", 32'(txByte), 32'(mTxByte));
        checkOutput("busy", 32'(busy), 32'((modelQ.size() != 0) || !modelIdle()));
    endtask

    // One clock: drive at the falling edge, advance the model at the rising edge,
    // compare at the next falling edge.
    task automatic applyStimulus(input bit we, input logic [7:0] d, input bit rdy);
        wrEn    = we;
        wrData  = d;
        txReady = rdy;
        @(posedge clock25);
        modelStep(we, d, rdy);
        @(negedge clock25);
        wrEn    = 1'b0;
        txReady = 1'b0;
        compareAll();
    endtask

    // Complete the frame in flight, sit through the gap, then hit the IDLE pop
    // cycle with an optional write.
    task automatic frameCycle(input bit we, input logic [7:0] d);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(we, d, 1'b0);
    endtask

    // Reset asserted between clock edges; outputs must clear immediately.
    task automatic doReset();
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("rstTxSend", 32'(txSend), 32'd0);
        checkOutput("rstCount", 32'(count), 32'd0);
        checkOutput("rstEmpty", 32'(empty), 32'd1);
        @(negedge clock25);
        @(negedge clock25);
        reset = 1'b0;
    endtask

    initial begin
        modelReset();
        @(negedge clock25);
        @(negedge clock25);
        reset = 1'b0;
        compareAll();

        // Single byte through the handshake.
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t1Idle", 32'(busy), 32'd0);
        applyStimulus(1'b1, 8'h55, 1'b0);
        checkOutput("t1Count", 32'(count), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t1TxSend", 32'(txSend), 32'd1);
        checkOutput("t1TxByte", 32'(txByte), 32'h55);
        checkOutput("t1Empty", 32'(empty), 32'd1);
        repeat (99) applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t1SendFall", 32'(txSend), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t1GapBusy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t1Busy", 32'(busy), 32'd0);

        // tx_ready in IDLE with nothing queued changes nothing.
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t4IdleBusy", 32'(busy), 32'd0);
        checkOutput("t4IdleSend", 32'(txSend), 32'd0);

        // Fill to full behind a stalled frame, then overflow.
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        checkOutput("t2Count", 32'(count), 32'd16);
        checkOutput("t2Full", 32'(full), 32'd1);
        applyStimulus(1'b1, 8'hAA, 1'b0);
        checkOutput("t2Overflow", 32'(overflow), 32'd1);
        checkOutput("t2CountHold", 32'(count), 32'd16);

        // Write while full coinciding with a pop is still rejected.
        frameCycle(1'b1, 8'h77);
        checkOutput("t6Overflow", 32'(overflow), 32'd1);
        checkOutput("t6Count", 32'(count), 32'd15);
        checkOutput("t6TxByte", 32'(txByte), 32'h01);
        while (modelQ.size() > 3) frameCycle(1'b0, 8'h00);
        frameCycle(1'b1, 8'h99);
        checkOutput("t6CountKeep", 32'(count), 32'd3);

        // tx_ready during GAP is ignored.
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t4GapSend", 32'(txSend), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t4GapCount", 32'(count), 32'd3);
        applyStimulus(1'b0, 8'h00, 1'b0);
        while (modelQ.size() > 0) frameCycle(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b1);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t2Drained", 32'(busy), 32'd0);

        // Transmitter never answers: watchdog abandons the byte.
        applyStimulus(1'b1, 8'h3C, 1'b0);
        applyStimulus(1'b1, 8'h4D, 1'b0);
        repeat (TIMEOUT - 1) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t3NoEarlyTimeout", 32'(timeoutErr), 32'd0);
        checkOutput("t3StillSending", 32'(txSend), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t3Timeout", 32'(timeoutErr), 32'd1);
        checkOutput("t3SendFall", 32'(txSend), 32'd0);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t3NextByte", 32'(txByte), 32'h4D);
        checkOutput("t3NextSend", 32'(txSend), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);

        // Reset in the middle of a send with bytes queued.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0);
        checkOutput("t5Queued", 32'(count), 32'd5);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
        doReset();
        repeat (49) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t5StillRecover", 32'(busy), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t5Idle", 32'(busy), 32'd0);
        applyStimulus(1'b1, 8'h5A, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t5Send", 32'(txSend), 32'd1);
        checkOutput("t5Byte", 32'(txByte), 32'h5A);
        applyStimulus(1'b0, 8'h00, 1'b1);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);

        // RECOVER leaves on its own watchdog without flagging an error.
        doReset();
        repeat (TIMEOUT - 1) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("rcvStillBusy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("rcvTimedOut", 32'(busy), 32'd0);
        checkOutput("rcvNoErr", 32'(timeoutErr), 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit         we;
            bit         rdy;
            logic [7:0] d;
            we  = ($urandom_range(0, 2) == 0);
            d   = 8'($urandom);
            rdy = mSending ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 39) == 0);
            applyStimulus(we, d, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
